psi_frame_ctrl: RTL
===================

PSI_FRAME_CTRL -- requirements
Module: psi_frame_ctrl

Interface
- REQ-001 The block SHALL have these parameters (name, default, meaning):
  - PSI_MIN, 32'd500000, lower clamp (PSI x 1e6).
  - PSI_MAX, 32'd2000000, upper clamp.
  - PSI_DEFAULT, 32'd1250000, reset value of psi_cur.
  - TIMEOUT, 8'd15, maximum WAIT cycles without calc_valid_out.
  - SMOOTH_SHIFT, 3'd2, IIR shift used when smooth_en=1.
- REQ-002 The block SHALL have one clock; reset is asynchronous and active-low.
- REQ-003 The block SHALL have these ports (name, direction, width, meaning):
  - clk, in, 1, clock.
  - rst, in, 1, asynchronous active-low reset.
  - al_valid, in, 1, atmospheric-light sample strobe.
  - ar / ag / ab, in, 8 each, atmospheric light.
  - frame_start, in, 1, one-cycle frame boundary pulse.
  - smooth_en, in, 1, enable IIR smoothing.
  - calc_ar / calc_ag / calc_ab, out, 8 each, operands to the PSI datapath.
  - calc_valid_in, out, 1, launch strobe to the datapath.
  - calc_psi, in, 32, datapath result, signed two's complement.
  - calc_valid_out, in, 1, datapath result strobe.
  - psi_cur, out, 32, PSI applied for the current frame.
  - psi_update, out, 1, one-cycle pulse when psi_cur changes.
  - busy, out, 1, high in any state other than IDLE.
  - err_timeout, out, 1, sticky timeout flag.
  - err_overrun, out, 1, sticky overrun flag.

Function
- REQ-004 On al_valid=1 in any state, {ar,ag,ab} SHALL be latched into a shadow register and the pending flag set; the latest sample wins.
- REQ-005 The FSM SHALL have exactly four states: IDLE, ISSUE, WAIT, APPLY.
- REQ-006 IDLE -> ISSUE SHALL occur when frame_start=1 and pending=1 (or al_valid=1 in the same cycle); with pending=0, frame_start SHALL be ignored.
- REQ-007 In ISSUE, calc_valid_in SHALL be 1 for exactly one cycle, calc_a* SHALL present the shadow values, pending SHALL clear, and the FSM SHALL go to WAIT.
- REQ-008 calc_a* SHALL hold their values from ISSUE until the next ISSUE.
- REQ-009 al_valid in the ISSUE cycle SHALL set pending again with the new sample.
- REQ-010 In WAIT, an 8-bit counter SHALL increment every cycle.
  - calc_valid_out=1: capture calc_psi and go to APPLY.
  - Counter reaches TIMEOUT first: set err_timeout, return to IDLE, leave psi_cur unchanged.
- REQ-011 calc_valid_out outside WAIT SHALL be ignored.
- REQ-012 In APPLY, the captured value SHALL be treated as signed and clamped to [PSI_MIN, PSI_MAX], giving target.
  - smooth_en=0: psi_cur <= target.
  - smooth_en=1: psi_cur <= psi_cur + ((target - psi_cur) >>> SMOOTH_SHIFT), using 33-bit signed difference and arithmetic shift.
- REQ-013 After APPLY the FSM SHALL return to IDLE, with psi_update=1 in the cycle the new psi_cur is first visible.
- REQ-014 Latency: frame_start sampled at edge N gives ISSUE during cycle N+1. With a 3-cycle datapath, psi_cur and psi_update are valid in cycle N+6.
- REQ-015 frame_start while busy=1 SHALL set err_overrun and SHALL NOT abort or restart the current sequence.
- REQ-016 err_timeout and err_overrun SHALL clear only on reset.
- REQ-017 psi_update SHALL pulse even when the new psi_cur equals the old value.

Reset
- REQ-018 While rst=0, the block SHALL hold these values:
  - FSM=IDLE, pending=0, counter=0.
  - calc_a*=0, calc_valid_in=0.
  - psi_cur=PSI_DEFAULT, psi_update=0, busy=0.
  - err_timeout=0, err_overrun=0.
- REQ-019 Assertion of rst mid-sequence (ISSUE/WAIT/APPLY) SHALL abandon the sequence immediately; a calc_valid_out arriving after release SHALL be ignored.

Verification
- REQ-020 The bench SHALL use a 3-cycle reference PSI model as the datapath and cover these scenarios:
  - Reset release, no stimulus -> psi_cur=1250000, busy=0, both error flags 0.
  - al_valid with ar=ag=ab=0, then frame_start, smooth_en=0 -> calc_valid_in one pulse; psi_cur=771580 with psi_update in cycle N+6.
  - ar=255, ag=0, ab=255 (raw 8780110) -> psi_cur=2000000; ag=255, ar=ab=0 (raw -6726185) -> psi_cur=500000.
  - smooth_en=1, SHIFT=2, from psi_cur=1250000, target 771580 -> psi_cur=1130395.
  - Datapath stub never asserts calc_valid_out -> busy drops after 15 WAIT cycles, err_timeout=1, psi_cur unchanged, no psi_update.
  - frame_start during WAIT -> err_overrun=1, sequence completes normally; rst=0 in WAIT, then a late calc_valid_out -> psi_cur stays 1250000.

Source files
------------

// File: rtl/psi_frame_ctrl_if.sv
// Handshake bundle between psi_frame_ctrl, its atmospheric-light source,
// the PSI datapath and the PSI consumer.
interface psi_frame_ctrl_if;
  logic        al_valid;
  logic [7:0]  ar;
  logic [7:0]  ag;
  logic [7:0]  ab;
  logic        frame_start;
  logic        smooth_en;
  logic [7:0]  calc_ar;
  logic [7:0]  calc_ag;
  logic [7:0]  calc_ab;
  logic        calc_valid_in;
  logic [31:0] calc_psi;
  logic        calc_valid_out;
  logic [31:0] psi_cur;
  logic        psi_update;
  logic        busy;
  logic        err_timeout;
  logic        err_overrun;

  modport slave (
    input  al_valid, ar, ag, ab, frame_start, smooth_en, calc_psi, calc_valid_out,
    output calc_ar, calc_ag, calc_ab, calc_valid_in, psi_cur, psi_update,
           busy, err_timeout, err_overrun
  );

  modport master (
    output al_valid, ar, ag, ab, frame_start, smooth_en, calc_psi, calc_valid_out,
    input  calc_ar, calc_ag, calc_ab, calc_valid_in, psi_cur, psi_update,
           busy, err_timeout, err_overrun
  );
endinterface

// File: rtl/psi_frame_ctrl.sv
// Per-frame PSI controller: launches the PSI datapath on the latest atmospheric
// light sample at each frame boundary, then clamps and optionally smooths the result.
module psi_frame_ctrl #(
  parameter logic [31:0] PSI_MIN      = 32'd500000,
  parameter logic [31:0] PSI_MAX      = 32'd2000000,
  parameter logic [31:0] PSI_DEFAULT  = 32'd1250000,
  parameter logic [7:0]  TIMEOUT      = 8'd15,
  parameter logic [2:0]  SMOOTH_SHIFT = 3'd2
) (
  input  logic             clk,
  input  logic             rst,
  psi_frame_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, APPLY} state_t;

  state_t       r_state;
  logic         r_pending;
  logic [23:0]  r_shadow;
  logic [7:0]   r_calc_ar;
  logic [7:0]   r_calc_ag;
  logic [7:0]   r_calc_ab;
  logic         r_calc_valid_in;
  logic [7:0]   r_cnt;
  logic [31:0]  r_psi_raw;
  logic [31:0]  r_psi_cur;
  logic         r_psi_update;
  logic         r_busy;
  logic         r_err_timeout;
  logic         r_err_overrun;

  logic [31:0]        w_target;
  logic signed [32:0] w_diff;
  logic [31:0]        w_psi_smooth;

  // Difference is taken at 33 bits so the arithmetic shift keeps the sign.
  always_comb begin
    w_target = r_psi_raw;
    if ($signed(r_psi_raw) < $signed(PSI_MIN)) begin
      w_target = PSI_MIN;
    end else if ($signed(r_psi_raw) > $signed(PSI_MAX)) begin
      w_target = PSI_MAX;
    end
    w_diff       = $signed({w_target[31], w_target}) - $signed({r_psi_cur[31], r_psi_cur});
    w_psi_smooth = r_psi_cur + 32'(w_diff >>> SMOOTH_SHIFT);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state         <= IDLE;
      r_pending       <= 1'b0;
      r_shadow        <= '0;
      r_calc_ar       <= '0;
      r_calc_ag       <= '0;
      r_calc_ab       <= '0;
      r_calc_valid_in <= 1'b0;
      r_cnt           <= '0;
      r_psi_raw       <= '0;
      r_psi_cur       <= PSI_DEFAULT;
      r_psi_update    <= 1'b0;
      r_busy          <= 1'b0;
      r_err_timeout   <= 1'b0;
      r_err_overrun   <= 1'b0;
    end else begin
      r_calc_valid_in <= 1'b0;
      r_psi_update    <= 1'b0;

      if (bus.al_valid) begin
        r_shadow  <= {bus.ar, bus.ag, bus.ab};
        r_pending <= 1'b1;
      end

      if (bus.frame_start && (r_state != IDLE)) begin
        r_err_overrun <= 1'b1;
      end

      // A sample arriving with frame_start is issued directly, so it never stays pending.
      case (r_state)
        IDLE: begin
          if (bus.frame_start && (r_pending || bus.al_valid)) begin
            r_state         <= ISSUE;
            r_busy          <= 1'b1;
            r_calc_valid_in <= 1'b1;
            r_pending       <= 1'b0;
            if (bus.al_valid) begin
              {r_calc_ar, r_calc_ag, r_calc_ab} <= {bus.ar, bus.ag, bus.ab};
            end else begin
              {r_calc_ar, r_calc_ag, r_calc_ab} <= r_shadow;
            end
          end
        end
        ISSUE: begin
          r_state <= WAIT;
          r_cnt   <= '0;
        end
        WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (bus.calc_valid_out) begin
            r_psi_raw <= bus.calc_psi;
            r_state   <= APPLY;
          end else if ((r_cnt + 8'd1) == TIMEOUT) begin
            r_err_timeout <= 1'b1;
            r_state       <= IDLE;
            r_busy        <= 1'b0;
          end
        end
        APPLY: begin
          r_psi_cur    <= bus.smooth_en ? w_psi_smooth : w_target;
          r_psi_update <= 1'b1;
          r_state      <= IDLE;
          r_busy       <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.calc_ar       = r_calc_ar;
  assign bus.calc_ag       = r_calc_ag;
  assign bus.calc_ab       = r_calc_ab;
  assign bus.calc_valid_in = r_calc_valid_in;
  assign bus.psi_cur       = r_psi_cur;
  assign bus.psi_update    = r_psi_update;
  assign bus.busy          = r_busy;
  assign bus.err_timeout   = r_err_timeout;
  assign bus.err_overrun   = r_err_overrun;

endmodule
